// File: rtl/ctrl_pipe_regs.sv
// Chained control-word pipeline registers with per-stage stall (hold) and flush (bubble).
// Optional CTRL_PIPE_PERF_EN adds a saturating count of edges where the last stage is empty.

module ctrl_pipe_stage #(
  parameter int          W      = 11,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         up_hold,
  input  logic         up_valid,
  input  logic [W-1:0] up_ctrl,
  output logic         valid,
  output logic [W-1:0] ctrl
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      ctrl  <= BUBBLE;
    end else if (hold) begin
      valid <= valid;
      ctrl  <= ctrl;
    end else if (up_hold) begin
      // upstream is frozen, so nothing moves into this stage
      valid <= 1'b0;
      ctrl  <= BUBBLE;
    end else begin
      valid <= up_valid;
      ctrl  <= up_valid ? up_ctrl : BUBBLE;
    end
  end
endmodule

module ctrl_pipe_regs #(
  parameter int           W      = 11,
  parameter int           STAGES = 3,
  parameter logic [W-1:0] BUBBLE = {W{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          in_ctrl,
  input  logic                  in_valid,
  input  logic [STAGES-1:0]     stall_vec,
  input  logic [STAGES-1:0]     flush_vec,
  output logic [STAGES*W-1:0]   out_ctrl,
  output logic [STAGES-1:0]     out_valid,
  output logic                  in_ready
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [15:0]           bubble_cnt
`endif
);
  logic [STAGES-1:0]        hold;
  logic [STAGES-1:0][W-1:0] ctrl_q;

  // a stall at stage k freezes everything upstream of it as well
  always_comb begin
    hold = '0;
    for (int i = 0; i < STAGES; i++) hold[i] = |(stall_vec >> i);
  end

  assign in_ready = ~hold[0];

  genvar i;
  for (i = 0; i < STAGES; i++) begin : g_stage
    logic         up_hold;
    logic         up_valid;
    logic [W-1:0] up_ctrl;

    if (i == 0) begin : g_head
      assign up_hold  = 1'b0;
      assign up_valid = in_valid;
      assign up_ctrl  = in_ctrl;
    end else begin : g_tail
      assign up_hold  = hold[i-1];
      assign up_valid = out_valid[i-1];
      assign up_ctrl  = ctrl_q[i-1];
    end

    ctrl_pipe_stage #(.W(W), .BUBBLE(BUBBLE)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_vec[i]),
      .hold     (hold[i]),
      .up_hold  (up_hold),
      .up_valid (up_valid),
      .up_ctrl  (up_ctrl),
      .valid    (out_valid[i]),
      .ctrl     (ctrl_q[i])
    );

    assign out_ctrl[i*W +: W] = ctrl_q[i];
  end

`ifdef CTRL_PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt <= 16'h0000;
    else if (!out_valid[STAGES-1] && bubble_cnt != 16'hFFFF)
      bubble_cnt <= bubble_cnt + 16'h0001;
  end
`endif
endmodule
